// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: owns the PC, issues imem requests, buffers words, redirects on PCSrc.
// Latency: a word is presented the cycle after its response; a redirect costs one dead REDIRECT cycle.
// Backpressure: requests are capped so buffered + in-flight never exceed FIFO_DEPTH (a same-cycle pop frees a slot).
module instr_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pcPlus4,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] branchTarget,
    input  logic [XLEN-1:0] jalrTarget
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {BOOT, FETCH, REDIRECT} state_t;

    state_t                state, state_nxt;
    logic [XLEN-1:0]       fetch_pc;
    logic [XLEN-1:0]       slot_pc  [FIFO_DEPTH];
    logic [XLEN-1:0]       slot_dat [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_full;
    logic [PW-1:0]         head, fillp, tail;
    logic [CW-1:0]         fifo_count, outstanding, discard, out_nxt;
    logic [CW:0]           occupancy;
    logic                  req_acc, rsp_take, rsp_drop, pop, redirect;
    logic [XLEN-1:0]       target_raw, target;

    assign pop      = instr_valid && instr_ready;
    assign redirect = pop && (PCSrc == 2'b01 || PCSrc == 2'b10);
    assign req_acc  = imem_req_valid && imem_req_ready;
    assign rsp_drop = imem_rsp_valid && (discard != '0);
    assign rsp_take = imem_rsp_valid && (discard == '0);
    assign out_nxt  = outstanding + CW'(req_acc) - CW'(imem_rsp_valid);

    // Counting the head being popped this cycle keeps a 1-cycle memory at one word per cycle.
    assign occupancy      = {1'b0, fifo_count} + {1'b0, outstanding} - (CW+1)'(pop);
    assign imem_req_valid = (state == FETCH) && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign target_raw = (PCSrc == 2'b10) ? jalrTarget : branchTarget;
    assign target     = target_raw & ~XLEN'(3);

    assign instr_valid   = slot_full[head];
    assign instr         = instr_valid ? slot_dat[head] : '0;
    assign instr_pc      = instr_valid ? slot_pc[head] : '0;
    assign instr_pcPlus4 = instr_valid ? slot_pc[head] + XLEN'(4) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:     state_nxt = FETCH;
            FETCH:    state_nxt = FETCH;
            REDIRECT: state_nxt = FETCH;
            default:  state_nxt = BOOT;
        endcase
        if (redirect) state_nxt = REDIRECT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            head        <= '0;
            fillp       <= '0;
            tail        <= '0;
            slot_full   <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            if (redirect) begin
                // Everything still in flight, including this cycle's accept, belongs to the wrong path.
                fetch_pc   <= target;
                head       <= '0;
                fillp      <= '0;
                tail       <= '0;
                slot_full  <= '0;
                fifo_count <= '0;
                discard    <= out_nxt;
            end else begin
                if (req_acc) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                    tail     <= tail + PW'(1);
                end
                if (rsp_take) fillp <= fillp + PW'(1);
                if (pop) head <= head + PW'(1);
                if (rsp_drop) discard <= discard - CW'(1);
                fifo_count <= fifo_count + CW'(rsp_take) - CW'(pop);
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (pop && head == PW'(i)) slot_full[i] <= 1'b0;
                    if (rsp_take && fillp == PW'(i)) slot_full[i] <= 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset: outputs are gated by the valid bits.
    always_ff @(posedge clk) begin
        if (req_acc && !redirect) slot_pc[tail] <= fetch_pc;
        if (rsp_take) slot_dat[fillp] <= imem_rsp_data;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, variable-latency instruction memory model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc, instr_pcPlus4;
    logic [1:0]  PCSrc;
    logic [31:0] branchTarget, jalrTarget;

    int checks = 0, failures = 0, cyc = 0, lat = 1, stab_err = 0;
    bit pat_en = 1'b0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] acc_q[$], mq_addr[$], dq_pc[$], dq_p4[$], dq_ins[$];
    int          mq_due[$], dq_cyc[$];

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pcPlus4(instr_pcPlus4),
        .PCSrc(PCSrc), .branchTarget(branchTarget), .jalrTarget(jalrTarget)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'h5A5A_0F13;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes just before the edge, then update the memory model after it.
    task automatic step();
        logic        acc, pop, hold, redir;
        logic [31:0] a, dq;
        int          di;
        #1;
        acc   = imem_req_valid && imem_req_ready;
        a     = imem_req_addr;
        pop   = instr_valid && instr_ready;
        hold  = imem_req_valid && !imem_req_ready;
        redir = pop && (PCSrc == 2'b01 || PCSrc == 2'b10);
        if (pop) begin
            dq_pc.push_back(instr_pc);
            dq_p4.push_back(instr_pcPlus4);
            dq_ins.push_back(instr);
            dq_cyc.push_back(cyc);
        end
        if (imem_rsp_valid) begin
            dq = mq_addr.pop_front();
            di = mq_due.pop_front();
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            acc_q.push_back(a);
            mq_addr.push_back(a);
            mq_due.push_back(cyc + lat - 1);
        end
        if (hold && !redir && (!imem_req_valid || imem_req_addr !== a)) stab_err++;
        if (pat_en) begin
            imem_req_ready = pat[cyc % 4];
            lat = 1 + (cyc % 3);
        end
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(mq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        PCSrc = 2'b00; branchTarget = '0; jalrTarget = '0;
        pat_en = 1'b0; imem_req_ready = 1'b1; lat = 1; instr_ready = 1'b1;
        acc_q.delete(); mq_addr.delete(); mq_due.delete();
        dq_pc.delete(); dq_p4.delete(); dq_ins.delete(); dq_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_deliv(input int n, input string tag);
        for (int i = 0; i < 400 && dq_pc.size() < n; i++) step();
        chk(tag, 32'(dq_pc.size() >= n), 32'd1);
    endtask

    task automatic wait_head(input logic [31:0] pc, input string tag);
        for (int i = 0; i < 400 && !(instr_valid && instr_pc == pc); i++) step();
        chk(tag, instr_pc, pc);
    endtask

    initial begin
        int n;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0; PCSrc = 2'b00; branchTarget = '0; jalrTarget = '0;
        #3 rst_n = 1'b0;
        #2;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_pcplus4", instr_pcPlus4, 32'h0);

        // Streaming from reset with a 1-cycle memory
        do_reset();
        chk("t1_boot_no_req", 32'(imem_req_valid), 32'd0);
        step();
        chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0);
        wait_deliv(3, "t1_deliv_timeout");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_pc%0d", i), dq_pc[i], 32'(4 * i));
            chk($sformatf("t1_p4_%0d", i), dq_p4[i], 32'(4 * i + 4));
            chk($sformatf("t1_ins%0d", i), dq_ins[i], memword(32'(4 * i)));
        end
        chk("t1_gap01", 32'(dq_cyc[1] - dq_cyc[0]), 32'd1);
        chk("t1_gap12", 32'(dq_cyc[2] - dq_cyc[1]), 32'd1);

        // Stalled consumer: issue stops at the buffer limit
        do_reset();
        instr_ready = 1'b0;
        repeat (7) step();
        chk("t2_acc_count", 32'(acc_q.size()), 32'd2);
        chk("t2_acc0", acc_q[0], 32'h0);
        chk("t2_acc1", acc_q[1], 32'h4);
        chk("t2_req_idle", 32'(imem_req_valid), 32'd0);
        chk("t2_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        wait_deliv(3, "t2_deliv_timeout");
        chk("t2_acc2", acc_q[2], 32'h8);
        chk("t2_pc1", dq_pc[1], 32'h4);
        chk("t2_pc2", dq_pc[2], 32'h8);

        // Branch redirect with responses in flight, then jalr with a misaligned target
        do_reset();
        lat = 2;
        wait_head(32'h8, "t3_reach_8");
        PCSrc = 2'b01; branchTarget = 32'h100;
        step();
        PCSrc = 2'b00; branchTarget = 32'hDEAD_BEE0;
        chk("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t3_redir_addr", imem_req_addr, 32'h100);
        chk("t3_redir_instr_valid", 32'(instr_valid), 32'd0);
        wait_head(32'h104, "t3_reach_104");
        chk("t3_after_8", dq_pc[3], 32'h100);
        chk("t3_ins_100", dq_ins[3], memword(32'h100));
        PCSrc = 2'b10; jalrTarget = 32'h203;
        step();
        PCSrc = 2'b00; jalrTarget = 32'hFFFF_FFFF;
        n = acc_q.size();
        for (int i = 0; i < 50 && acc_q.size() <= n; i++) step();
        chk("t4_jalr_req_addr", acc_q[n], 32'h200);
        wait_deliv(6, "t4_deliv_timeout");
        chk("t4_after_104", dq_pc[5], 32'h200);
        chk("t4_p4_200", dq_p4[5], 32'h204);

        // Stuttering request ready and 1-3 cycle latency; PCSrc=11 acts as sequential
        do_reset();
        pat_en = 1'b1;
        PCSrc = 2'b11; branchTarget = 32'h300; jalrTarget = 32'h400;
        wait_deliv(8, "t5_deliv_timeout");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_pc%0d", i), dq_pc[i], 32'(4 * i));
            chk($sformatf("t5_ins%0d", i), dq_ins[i], memword(32'(4 * i)));
        end
        chk("t5_req_stable", 32'(stab_err), 32'd0);

        // Asynchronous reset with words buffered
        do_reset();
        instr_ready = 1'b0;
        repeat (6) step();
        chk("t6_buffered_valid", 32'(instr_valid), 32'd1);
        chk("t6_buffered_pc", instr_pc, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_instr_valid", 32'(instr_valid), 32'd0);
        chk("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
        do_reset();
        wait_deliv(2, "t6_deliv_timeout");
        chk("t6_restart_acc", acc_q[0], 32'h0);
        chk("t6_restart_pc0", dq_pc[0], 32'h0);
        chk("t6_restart_pc1", dq_pc[1], 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
